mult_shift_add_ctrl: RTL and testbench
======================================

// Module: mult_shift_add_ctrl
// PURPOSE
//   Sequential shift-add unsigned multiplier: control FSM plus datapath for the Multiplicador unit.
//   Sits directly upstream of the iteration Counter.
//   - Drives the Counter's Load input.
//   - Consumes its K (terminal-count) output to end the add/shift loop.
//   Produces a 2*WIDTH-bit product after WIDTH iterations.
// PARAMETERS
//   WIDTH    16   operand width in bits; must be <= 16 to match the 4-bit Counter range
// PORTS
//   Clk           in   1        single clock; all state updates on its rising edge
//   Reset         in   1        synchronous, active-high reset
//   Start         in   1        request to multiply; sampled only in IDLE
//   Multiplicand  in   WIDTH    operand A; captured on Start acceptance
//   Multiplier    in   WIDTH    operand B; captured on Start acceptance
//   K             in   1        Counter terminal flag: high while count == WIDTH-1
//   Load          out  1        clears the Counter to 0 at the next edge
//   Product       out  2*WIDTH  result; valid from Done until next accepted Start
//   Busy          out  1        high in INIT and CALC
//   Done          out  1        one-cycle pulse: Product is final
//   Err           out  1        sticky mismatch between K and local iteration count
// BEHAVIOUR
//   Counter contract
//     - Load=1 clears count to 0.
//     - Otherwise count increments each Clk.
//     - K = (count == WIDTH-1).
//   Reset (synchronous, Reset=1 at edge)
//     - State goes to IDLE; Product, Done, Busy, Err and the iteration register go to 0.
//     - Load = 1 combinationally while Reset is high, so the Counter clears with this block.
//   FSM states: IDLE, INIT, CALC, DONE
//     - IDLE: Busy=0. Start=1 at the edge -> INIT.
//       - Capture A<=Multiplicand, Q<=Multiplier.
//       - Clear P_hi (WIDTH+1 bits incl. carry), local iter register and Err.
//     - INIT: Load=1, Busy=1. -> CALC unconditionally.
//     - CALC: Busy=1, Load=0. Each edge performs one iteration:
//       - sum = P_hi + (Q[0] ? A : 0), computed WIDTH+1 bits wide, no overflow loss.
//       - {P_hi,Q} <= {sum,Q} >> 1; iter <= iter + 1.
//       - Terminate when K=1 or iter==WIDTH-1; the iteration on that edge is still performed.
//       - On termination: Product <= shifted {P_hi[WIDTH-1:0],Q}; go to DONE.
//       - Err <= 1 if K and (iter==WIDTH-1) disagree on that edge.
//     - DONE: Done=1 for exactly one cycle, Busy=0. -> IDLE unconditionally.
//   Latency
//     - Start accepted at edge N: INIT after N, CALC from N+1.
//     - Product/Done updated at edge N+WIDTH+1.
//     - Done falls at edge N+WIDTH+2. Next Start can be accepted at edge N+WIDTH+2.
//   Input gating
//     - Start in INIT/CALC/DONE is ignored; no queuing.
//     - Operand changes after acceptance have no effect.
//     - K outside CALC is ignored and does not set Err.
//   Product and Err hold value in IDLE; they change only on reset, termination, or Start acceptance (Err cleared).
//   Reset mid-operation: abort immediately; no Done pulse; Product=0.
// TESTING
//   Bench instantiates Counter with terminal at WIDTH-1 (WIDTH=16); Clk period 40ns.
//   1. A=3, B=5, Start 1 cycle -> Busy for 17 cycles; Done pulse at edge N+17 with Product=32'd15, Err=0.
//   2. A=16'hFFFF, B=16'hFFFF -> Product=32'hFFFE0001; A=0, B=16'h1234 -> Product=0.
//   3. Start held high through whole op -> exactly one result per IDLE visit; operands changed mid-CALC do not affect Product.
//   4. Reset pulsed at 5th CALC cycle -> next edge: IDLE, Busy=0, Product=0, Load=1 during Reset, no Done pulse; a new op then gives the correct result.
//   5. Forced K=1 in 3rd CALC cycle (counter bypassed) -> early termination, Done pulses, Err=1. Next Start clears Err.
//   6. Back-to-back ops (Start at Done+1): 7*9 then 100*200 -> Product 63 then 20000, each with one Done pulse.

Source files
------------

// File: rtl/mult_shift_add_ctrl_if.sv
// Handshake and operand/result bundle between a multiply requester and the
// shift-add multiplier control, including the iteration Counter's Load/K pair.
interface mult_shift_add_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic                 Start;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic                 K;
  logic                 Load;
  logic [2*WIDTH-1:0]   Product;
  logic                 Busy;
  logic                 Done;
  logic                 Err;

  modport master (
    output Start, Multiplicand, Multiplier, K,
    input  Load, Product, Busy, Done, Err
  );

  modport slave (
    input  Start, Multiplicand, Multiplier, K,
    output Load, Product, Busy, Done, Err
  );
endinterface

// File: rtl/mult_shift_add_ctrl.sv
// Sequential shift-add unsigned multiplier: IDLE/INIT/CALC/DONE control plus
// datapath, paced by an external iteration Counter through Load and K.
module mult_shift_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  mult_shift_add_ctrl_if.slave   bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH:0]       p_hi_q, p_hi_d;
  logic [IW-1:0]        iter_q, iter_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     shifted;
  logic                 iter_last;
  logic                 finish;

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no branch can infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    p_hi_d    = p_hi_q;
    iter_d    = iter_q;
    product_d = product_q;
    err_d     = err_q;
    done_d    = 1'b0;

    // P_hi keeps a carry bit so the add never loses its top bit before the shift.
    sum       = p_hi_q + (q_q[0] ? {1'b0, a_q} : '0);
    shifted   = {sum, q_q} >> 1;
    iter_last = (iter_q == IW'(WIDTH - 1));
    finish    = bus.K || iter_last;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_INIT;
          a_d     = bus.Multiplicand;
          q_d     = bus.Multiplier;
          p_hi_d  = '0;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_INIT: begin
        state_d = S_CALC;
      end
      S_CALC: begin
        p_hi_d = shifted[2*WIDTH:WIDTH];
        q_d    = shifted[WIDTH-1:0];
        iter_d = iter_q + IW'(1);
        if (finish) begin
          state_d   = S_DONE;
          product_d = shifted[2*WIDTH-1:0];
          done_d    = 1'b1;
          // Counter and local count must agree on the final iteration.
          err_d     = err_q | (bus.K != iter_last);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_INIT) || (state_d == S_CALC);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      iter_q    <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // NOTE: operand and partial-product registers are left unreset; they are always loaded on Start before use.
  always_ff @(posedge Clk) begin
    a_q    <= a_d;
    q_q    <= q_d;
    p_hi_q <= p_hi_d;
  end

  // Load also follows Reset directly so the Counter clears alongside this block.
  assign bus.Load    = Reset || (state_q == S_INIT);
  assign bus.Product = product_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Err     = err_q;

endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// Directed bench for mult_shift_add_ctrl driven by a model of the 4-bit
// iteration Counter, with a K override for the early-termination case.
module tb_mult_shift_add_ctrl;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  mult_shift_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mult_shift_add_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  logic [3:0] cnt;
  logic       k_force;

  always_ff @(posedge clk) begin
    if (bus.Load) cnt <= '0;
    else          cnt <= cnt + 4'd1;
  end

  assign bus.K = k_force | (cnt == 4'(WIDTH - 1));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Caller sits just after a falling edge; Start is presented for one rising edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p);
    int lat;
    int busy_cnt;
    bus.Start        = 1'b1;
    bus.Multiplicand = a;
    bus.Multiplier   = b;
    @(negedge clk);
    bus.Start = 1'b0;
    check({tag, "_busy_accept"}, bus.Busy, 1);
    check({tag, "_err_clear"}, bus.Err, 0);
    lat      = 0;
    busy_cnt = 0;
    while (!bus.Done && lat < 40) begin
      busy_cnt += int'(bus.Busy);
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_latency"}, lat, LAT);
    check({tag, "_busy_cycles"}, busy_cnt, LAT);
    check({tag, "_product"}, bus.Product, exp_p);
    check({tag, "_err"}, bus.Err, 0);
    @(negedge clk);
    check({tag, "_done_fall"}, bus.Done, 0);
    check({tag, "_product_hold"}, bus.Product, exp_p);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          dones;
    logic [31:0] prods[2];
    logic        prev_done;
    bit          dbl_done;

    vecs[0] = '{16'd3,      16'd5,      32'd15};
    vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001};
    vecs[2] = '{16'h0000,   16'h1234,   32'd0};
    vecs[3] = '{16'd7,      16'd9,      32'd63};
    vecs[4] = '{16'd100,    16'd200,    32'd20000};
    vecs[5] = '{16'h0001,   16'hFFFF,   32'h0000FFFF};
    vecs[6] = '{16'hFFFF,   16'h0001,   32'h0000FFFF};
    vecs[7] = '{16'h8000,   16'h0002,   32'h00010000};
    vecs[8] = '{16'h1234,   16'h5678,   32'd103153760};

    bus.Start        = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    k_force          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_load", bus.Load, 1);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_product", bus.Product, 0);
    check("rst_err", bus.Err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_load", bus.Load, 0);

    // Table: back-to-back ops, each Start presented right after the previous Done falls
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Start held high; operands changed mid-CALC only reach the next accepted op
    bus.Multiplicand = 16'd6;
    bus.Multiplier   = 16'd7;
    bus.Start        = 1'b1;
    dones     = 0;
    prods[0]  = '0;
    prods[1]  = '0;
    prev_done = 1'b0;
    dbl_done  = 1'b0;
    @(negedge clk);
    check("held_busy", bus.Busy, 1);
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus.Multiplicand = 16'd1;
        bus.Multiplier   = 16'd1;
      end
      if (bus.Done) begin
        if (dones < 2) prods[dones] = bus.Product;
        dones++;
      end
      if (bus.Done && prev_done) dbl_done = 1'b1;
      prev_done = bus.Done;
    end
    bus.Start = 1'b0;
    check("held_done_count", dones, 2);
    check("held_single_pulse", dbl_done, 0);
    check("held_product0", prods[0], 32'd42);
    check("held_product1", prods[1], 32'd1);
    @(negedge clk);
    check("held_idle", bus.Busy, 0);

    // Reset during the 5th CALC cycle
    bus.Multiplicand = 16'd11;
    bus.Multiplier   = 16'd13;
    bus.Start        = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (5) @(negedge clk);
    check("calc_load", bus.Load, 0);
    check("calc_busy", bus.Busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_load", bus.Load, 1);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", bus.Busy, 0);
    check("midrst_product", bus.Product, 0);
    check("midrst_done", bus.Done, 0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_op("post_rst", 16'd11, 16'd13, 32'd143);

    // K outside CALC is ignored
    k_force = 1'b1;
    @(negedge clk);
    k_force = 1'b0;
    check("idle_k_err", bus.Err, 0);
    check("idle_k_busy", bus.Busy, 0);

    // Forced K in the 3rd CALC cycle: 3 iterations of 3*5 -> (3*(5 mod 8)) << 13
    bus.Multiplicand = 16'd3;
    bus.Multiplier   = 16'd5;
    bus.Start        = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    k_force = 1'b1;
    @(negedge clk);
    k_force = 1'b0;
    check("early_done", bus.Done, 1);
    check("early_product", bus.Product, 32'h0001E000);
    check("early_err", bus.Err, 1);
    @(negedge clk);
    check("early_done_fall", bus.Done, 0);
    check("early_err_hold", bus.Err, 1);
    @(negedge clk);
    check("early_err_idle", bus.Err, 1);
    check("early_product_hold", bus.Product, 32'h0001E000);
    run_op("after_err", 16'd2, 16'd3, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
